fd_queue: RTL and testbench

Parametrised Fetch-to-Decode pipeline buffer for the 8-bit pipeline processor, replacing the single-entry F/D latch. It holds up to DEPTH instruction/PC pairs in a circular buffer with a valid/ready handshake. Fetch can keep running while Decode stalls until the buffer fills. Flush empties every entry in one cycle and presents a NOP to Decode.

---
 rtl/fd_queue.sv | 91 +++++++++
 tb/tb_fd_queue.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fd_queue.sv
// rtl/fd_queue.sv - Fetch-to-Decode circular instruction buffer with valid/ready handshake.
// Optional FDQ_PERF_EN adds saturating stall/bubble performance counters.
module fd_queue #(
   parameter int                 INSTR_W = 8,
   parameter int                 PC_W    = 8,
   parameter int                 DEPTH   = 2,
   parameter logic [INSTR_W-1:0] NOP     = '0,
   parameter int                 CNT_W   = $clog2(DEPTH+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               FlushD,
   input  logic               StallD,
   input  logic               validF,
   input  logic [INSTR_W-1:0] instrF,
   input  logic [PC_W-1:0]    pcF,
   output logic               readyF,
   output logic               validD,
   output logic [INSTR_W-1:0] instrD,
   output logic [PC_W-1:0]    pcD,
   output logic [CNT_W-1:0]   count
`ifdef FDQ_PERF_EN
   ,
   output logic [15:0]        stall_cnt,
   output logic [15:0]        bubble_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [INSTR_W-1:0] instrMem [DEPTH];
   logic [PC_W-1:0]    pcMem    [DEPTH];
   logic [PTR_W-1:0]   rdPtr;
   logic [PTR_W-1:0]   wrPtr;
   logic               push;
   logic               pop;

   // Handshake depends only on registered count, so StallD never reaches readyF.
   assign readyF = (count != CNT_W'(DEPTH));
   assign validD = (count != '0);
   assign push   = validF && readyF && !FlushD;
   assign pop    = validD && !StallD && !FlushD;

   assign instrD = validD ? instrMem[rdPtr] : NOP;
   assign pcD    = validD ? pcMem[rdPtr]    : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         instrMem[wrPtr] <= instrF;
         pcMem[wrPtr]    <= pcF;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (FlushD) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push)
            wrPtr <= wrPtr + 1'b1;
         if (pop)
            rdPtr <= rdPtr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef FDQ_PERF_EN
   // Counters survive a flush; the flush cycle itself is not attributed to either.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else if (!FlushD) begin
         if (validD && StallD && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
         if (!validD && !StallD && bubble_cnt != 16'hFFFF)
            bubble_cnt <= bubble_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fd_queue.sv
// tb/tb_fd_queue.sv - directed self-checking bench for fd_queue (DEPTH=2 and DEPTH=4 instances).
module tb_fd_queue;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       flushA, stallA, validFA, readyA, validDA;
   logic [7:0] instrFA, pcFA, instrDA, pcDA;
   logic [1:0] countA;

   logic       flushB, stallB, validFB, readyB, validDB;
   logic [7:0] instrFB, pcFB, instrDB, pcDB;
   logic [2:0] countB;

`ifdef FDQ_PERF_EN
   logic [15:0] stallCntA, bubbleCntA, stallCntB, bubbleCntB;
`endif

   fd_queue #(.INSTR_W(8), .PC_W(8), .DEPTH(2), .NOP(8'h00)) dutA (
      .clk(clk), .rst(rst), .FlushD(flushA), .StallD(stallA),
      .validF(validFA), .instrF(instrFA), .pcF(pcFA), .readyF(readyA),
      .validD(validDA), .instrD(instrDA), .pcD(pcDA), .count(countA)
`ifdef FDQ_PERF_EN
      , .stall_cnt(stallCntA), .bubble_cnt(bubbleCntA)
`endif
   );

   fd_queue #(.INSTR_W(8), .PC_W(8), .DEPTH(4), .NOP(8'h00)) dutB (
      .clk(clk), .rst(rst), .FlushD(flushB), .StallD(stallB),
      .validF(validFB), .instrF(instrFB), .pcF(pcFB), .readyF(readyB),
      .validD(validDB), .instrD(instrDB), .pcD(pcDB), .count(countB)
`ifdef FDQ_PERF_EN
      , .stall_cnt(stallCntB), .bubble_cnt(bubbleCntB)
`endif
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkA(input string tag, input logic v, input logic [7:0] ins,
                         input logic [7:0] pc, input logic [1:0] cnt, input logic rdy);
      check({tag, ".validD"}, 32'(validDA), 32'(v));
      check({tag, ".instrD"}, 32'(instrDA), 32'(ins));
      check({tag, ".pcD"},    32'(pcDA),    32'(pc));
      check({tag, ".count"},  32'(countA),  32'(cnt));
      check({tag, ".readyF"}, 32'(readyA),  32'(rdy));
   endtask

   logic [7:0] expQ[$];
   logic [7:0] expPc[$];
   logic [31:0] stallPat;
   int sent, got, cyc;
   logic doPop, doPush;

   initial begin
      {flushA, stallA, validFA, instrFA, pcFA} = '0;
      {flushB, stallB, validFB, instrFB, pcFB} = '0;
      step();
      rst = 1'b0;

      // one entry held, then asynchronous reset mid-cycle
      stallA = 1'b1; validFA = 1'b1; instrFA = 8'h5A; pcFA = 8'h07;
      step();
      validFA = 1'b0;
      checkA("hold", 1'b1, 8'h5A, 8'h07, 2'd1, 1'b1);
      #2 rst = 1'b1;
      #1 checkA("async_rst", 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
      #1 rst = 1'b0;
      stallA = 1'b0;
      step();

      // streaming: latency one cycle, count holds at 1
      validFA = 1'b1; instrFA = 8'hA1; pcFA = 8'h00;
      step();
      checkA("stream1", 1'b1, 8'hA1, 8'h00, 2'd1, 1'b1);
      instrFA = 8'hA2; pcFA = 8'h01;
      step();
      checkA("stream2", 1'b1, 8'hA2, 8'h01, 2'd1, 1'b1);
      validFA = 1'b0;
      step();
      checkA("stream_empty", 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);

      // stall fill: third push refused while full, delivered in order after release
      stallA = 1'b1; validFA = 1'b1; instrFA = 8'h11; pcFA = 8'h10;
      step();
      checkA("fill1", 1'b1, 8'h11, 8'h10, 2'd1, 1'b1);
      instrFA = 8'h22; pcFA = 8'h11;
      step();
      checkA("fill2", 1'b1, 8'h11, 8'h10, 2'd2, 1'b0);
      instrFA = 8'h33; pcFA = 8'h12;
      step();
      checkA("fill_refuse", 1'b1, 8'h11, 8'h10, 2'd2, 1'b0);
      stallA = 1'b0;
      step();
      checkA("drain22", 1'b1, 8'h22, 8'h11, 2'd1, 1'b1);
      step();
      validFA = 1'b0;
      checkA("drain33", 1'b1, 8'h33, 8'h12, 2'd1, 1'b1);
      step();
      checkA("drain_empty", 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);

      // flush while full discards the entries and the flush-cycle push
      stallA = 1'b1; validFA = 1'b1; instrFA = 8'h55; pcFA = 8'h20;
      step();
      instrFA = 8'h66; pcFA = 8'h21;
      step();
      checkA("pre_flush", 1'b1, 8'h55, 8'h20, 2'd2, 1'b0);
      flushA = 1'b1; instrFA = 8'h44; pcFA = 8'h22;
      step();
      checkA("flush", 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
      flushA = 1'b0; validFA = 1'b0; stallA = 1'b0;
      step();
      checkA("post_flush", 1'b0, 8'h00, 8'h00, 2'd0, 1'b1);
      validFA = 1'b1; instrFA = 8'h77; pcFA = 8'h23;
      step();
      validFA = 1'b0;
      checkA("after_flush_push", 1'b1, 8'h77, 8'h23, 2'd1, 1'b1);
      step();

      // DEPTH=4 wrap-around: 10 pushes with intermittent stall, scoreboard model
      stallPat = 32'b0000_0000_0000_0000_0000_1111_0011_1111;
      sent = 0; got = 0; cyc = 0;
      while (got < 10 && cyc < 60) begin
         check("wrap.count",  32'(countB), 32'(expQ.size()));
         check("wrap.readyF", 32'(readyB), 32'(expQ.size() != 4));
         check("wrap.validD", 32'(validDB), 32'(expQ.size() != 0));
         stallB  = stallPat[cyc % 32];
         doPop   = (expQ.size() != 0) && !stallB;
         doPush  = (sent < 10) && (expQ.size() != 4);
         validFB = (sent < 10);
         instrFB = 8'hC0 + 8'(sent);
         pcFB    = 8'(sent * 2);
         if (doPop) begin
            check("wrap.instrD", 32'(instrDB), 32'(expQ[0]));
            check("wrap.pcD",    32'(pcDB),    32'(expPc[0]));
         end
         step();
         if (doPop) begin
            void'(expQ.pop_front());
            void'(expPc.pop_front());
            got++;
         end
         if (doPush) begin
            expQ.push_back(8'hC0 + 8'(sent));
            expPc.push_back(8'(sent * 2));
            sent++;
         end
         cyc++;
      end
      validFB = 1'b0; stallB = 1'b0;
      check("wrap.delivered", 32'(got), 32'd10);
      step();
      check("wrap.end_count", 32'(countB), 32'd0);

`ifdef FDQ_PERF_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("perf.rst_stall",  32'(stallCntA),  32'd0);
      check("perf.rst_bubble", 32'(bubbleCntA), 32'd0);
      stallA = 1'b1; validFA = 1'b1; instrFA = 8'h99; pcFA = 8'h30;
      step();
      validFA = 1'b0;
      repeat (5) step();
      stallA = 1'b0;
      step();
      repeat (3) step();
      check("perf.stall",  32'(stallCntA),  32'd5);
      check("perf.bubble", 32'(bubbleCntA), 32'd3);
      flushA = 1'b1;
      step();
      flushA = 1'b0;
      check("perf.flush_stall",  32'(stallCntA),  32'd5);
      check("perf.flush_bubble", 32'(bubbleCntA), 32'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
